// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle radix-2 multiply / restoring divide, signed or unsigned.
// Optional build macro MULDIV_EARLY_EXIT_EN: a multiply leaves CALC as soon as
// the remaining multiplier bits are zero, and the product is re-aligned in FIX.
// busy/done are registered copies of the state, so they trail it by one cycle.
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_div,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             zero,
   output logic             div0
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // S_DZ is the single wait cycle of a divide-by-zero on its way to DONE.
   typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_DONE, S_DZ} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               div_q, div_d;
   logic               neg_q, neg_d;        // result sign: sa ^ sb
   logic               sa_q, sa_d;          // dividend sign, used for the remainder
   logic [WIDTH-1:0]   hi_q, hi_d;          // partial product high / partial remainder
   logic [WIDTH-1:0]   lo_q, lo_d;          // multiplier+product low / dividend+quotient
   logic [WIDTH-1:0]   opb_q, opb_d;        // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   res_lo_q, res_lo_d;
   logic [WIDTH-1:0]   res_hi_q, res_hi_d;
   logic               zero_q, zero_d;
   logic               div0_q, div0_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef MULDIV_EARLY_EXIT_EN
   logic [WIDTH-1:0]   mpl_q, mpl_d;        // multiplier bits not yet consumed
`endif

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               accept;

   // Next-state, datapath step and result formation.
   always_comb begin
      abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
      abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_sub   = div_shift[WIDTH-1:0] - opb_q;
`ifdef MULDIV_EARLY_EXIT_EN
      // cnt_q holds the shift steps skipped by leaving CALC early.
      prod_raw  = {hi_q, lo_q} >> cnt_q;
`else
      prod_raw  = {hi_q, lo_q};
`endif
      prod_fix  = neg_q ? -prod_raw : prod_raw;
      quo_fix   = neg_q ? -lo_q : lo_q;
      rem_fix   = sa_q ? -hi_q : hi_q;
      accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      zero_d   = zero_q;
      div0_d   = div0_q;
`ifdef MULDIV_EARLY_EXIT_EN
      mpl_d    = mpl_q;
`endif

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               div_d = op_div;
               sa_d  = op_signed & a[WIDTH-1];
               neg_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               cnt_d = CNT_W'(WIDTH);
               hi_d  = '0;
               lo_d  = op_div ? abs_a : abs_b;
               opb_d = op_div ? abs_b : abs_a;
`ifdef MULDIV_EARLY_EXIT_EN
               mpl_d = abs_b;
`endif
               if (op_div && (b == '0)) begin
                  lo_d    = a;             // raw dividend is returned as the remainder
                  state_d = S_DZ;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_DZ: begin
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = lo_q;
            zero_d   = 1'b0;
            div0_d   = 1'b1;
         end
         S_CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
               hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
               hi_d = mul_sum[WIDTH:1];
               lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_W'(1))
               state_d = S_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
            mpl_d = mpl_q >> 1;
            if (!div_q && (mpl_d == '0))
               state_d = S_FIX;
`endif
         end
         S_FIX: begin
            state_d = S_DONE;
            div0_d  = 1'b0;
            if (div_q) begin
               res_lo_d = quo_fix;
               res_hi_d = rem_fix;
               zero_d   = (quo_fix == '0);
            end else begin
               res_lo_d = prod_fix[WIDTH-1:0];
               res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
               zero_d   = (prod_fix == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_q == S_CALC) || (state_q == S_FIX);
      done_d = (state_q == S_DONE);
   end

   // State, datapath and registered outputs; rst clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         zero_q   <= 1'b0;
         div0_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
         mpl_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         zero_q   <= zero_d;
         div0_q   <= div0_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MULDIV_EARLY_EXIT_EN
         mpl_q    <= mpl_d;
`endif
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;
   assign zero   = zero_q;
   assign div0   = div0_q;

endmodule
